control_unit_pipe: RTL and testbench

Next-generation RV32I(+M) decode-stage control. It decodes op/funct3/funct7 in Decode and registers the control word into Execute, with stall/flush support. It adds optional M-extension decode and a multi-cycle mul/div sequencer that holds Execute and requests an upstream stall for the operation's latency. It sits between the instruction register (D) and the Execute datapath, alongside the hazard unit.

---
 rtl/control_unit_pipe.sv | 228 ++++++++++++++++++++++
 tb/tb_control_unit_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_pipe.sv
// RV32I(+M) decode-stage control: decodes D, registers the control word into E,
// and sequences multi-cycle mul/div operations by holding E and stalling upstream.
module control_unit_pipe #(
  parameter int ENABLE_M = 1,
  parameter int MUL_LAT  = 2,
  parameter int DIV_LAT  = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_D,
  input  logic [2:0] funct3_D,
  input  logic [6:0] funct7_D,
  input  logic       stall_D,
  input  logic       flush_E,
  output logic [2:0] ImmSrc_D,
  output logic       RegWrite_E,
  output logic       MemWrite_E,
  output logic [1:0] ResultSrc_E,
  output logic [2:0] Branch_E,
  output logic [1:0] Jump_E,
  output logic [3:0] ALUControl_E,
  output logic       ALUSrcA_E,
  output logic       ALUSrcB_E,
  output logic       LoadSign_E,
  output logic [1:0] SizeSrc_E,
  output logic [2:0] MulDivOp_E,
  output logic       md_start_E,
  output logic       md_done_E,
  output logic       stall_req,
  output logic       illegal_E
);

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic [2:0] branch;
    logic [1:0] jump;
    logic [3:0] aluctl;
    logic       srca;
    logic       srcb;
    logic       loadsign;
    logic [1:0] size;
    logic [2:0] mdop;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{regwrite: 1'b0, memwrite: 1'b0, resultsrc: 2'b00,
                                 branch: 3'b010, jump: 2'b00, aluctl: 4'b0000,
                                 srca: 1'b0, srcb: 1'b0, loadsign: 1'b0,
                                 size: 2'b00, mdop: 3'b000, illegal: 1'b0};

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b1000;
      3'b010:  alu_op = 4'b0110;
      3'b011:  alu_op = 4'b0101;
      3'b100:  alu_op = 4'b0100;
      3'b101:  alu_op = alt ? 4'b1010 : 4'b1001;
      3'b110:  alu_op = 4'b0011;
      default: alu_op = 4'b0010;
    endcase
  endfunction

  function automatic logic [1:0] size_sel(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   size_sel = 2'b10;
      2'b01:   size_sel = 2'b01;
      default: size_sel = 2'b00;
    endcase
  endfunction

  ctrl_t  dec, e_q, e_d;
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, lat_cnt;
  logic   retired_q, retired_d;
  logic   is_md;

  always_comb begin
    dec      = CTRL_NOP;
    ImmSrc_D = 3'b000;
    case (op_D)
      7'b0110011: begin
        if (funct7_D == 7'b0000001) begin
          if (ENABLE_M != 0) begin
            dec.regwrite  = 1'b1;
            dec.resultsrc = 2'b11;
            dec.mdop      = funct3_D;
          end else begin
            dec.illegal = 1'b1;
            ImmSrc_D    = 3'b111;
          end
        end else begin
          dec.regwrite = 1'b1;
          dec.aluctl   = alu_op(funct3_D, funct7_D[5]);
        end
      end
      7'b0010011: begin
        dec.regwrite = 1'b1;
        dec.srcb     = 1'b1;
        dec.aluctl   = alu_op(funct3_D, (funct3_D == 3'b101) && funct7_D[5]);
        ImmSrc_D     = (funct3_D[1:0] == 2'b01) ? 3'b101 : 3'b000;
      end
      7'b0000011: begin
        dec.regwrite  = 1'b1;
        dec.resultsrc = 2'b01;
        dec.srcb      = 1'b1;
        dec.loadsign  = ~funct3_D[2];
        dec.size      = size_sel(funct3_D);
      end
      7'b0100011: begin
        dec.memwrite = 1'b1;
        dec.srcb     = 1'b1;
        dec.size     = size_sel(funct3_D);
        ImmSrc_D     = 3'b001;
      end
      7'b1100011: begin
        dec.aluctl = 4'b0001;
        if (funct3_D[2:1] != 2'b01) dec.branch = funct3_D;
        ImmSrc_D   = 3'b010;
      end
      7'b1101111: begin
        dec.regwrite  = 1'b1;
        dec.resultsrc = 2'b10;
        dec.jump      = 2'b10;
        dec.srca      = 1'b1;
        dec.srcb      = 1'b1;
        ImmSrc_D      = 3'b011;
      end
      7'b1100111: begin
        dec.regwrite  = 1'b1;
        dec.resultsrc = 2'b10;
        dec.jump      = 2'b11;
        dec.srcb      = 1'b1;
      end
      7'b0110111: begin
        dec.regwrite = 1'b1;
        dec.srcb     = 1'b1;
        dec.aluctl   = 4'b0111;
        ImmSrc_D     = 3'b100;
      end
      7'b0010111: begin
        dec.regwrite = 1'b1;
        dec.srca     = 1'b1;
        dec.srcb     = 1'b1;
        ImmSrc_D     = 3'b100;
      end
      default: begin
        dec.illegal = 1'b1;
        ImmSrc_D    = 3'b111;
      end
    endcase
  end

  // A completed M-op still held by stall_D is marked retired so it cannot restart.
  assign is_md      = (e_q.resultsrc == 2'b11);
  assign lat_cnt    = e_q.mdop[2] ? DIV_CNT : MUL_CNT;
  assign stall_req  = is_md && !retired_q && (state_q != S_DONE);
  assign md_start_E = is_md && !retired_q && (state_q == S_IDLE) && !flush_E;
  assign md_done_E  = (state_q == S_DONE) && !flush_E;

  always_comb begin
    e_d       = e_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    retired_d = retired_q;
    if (flush_E) begin
      e_d       = CTRL_NOP;
      state_d   = S_IDLE;
      cnt_d     = 6'd0;
      retired_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (md_start_E) begin
          state_d = (lat_cnt == 6'd0) ? S_DONE : S_BUSY;
          cnt_d   = lat_cnt;
        end
        S_BUSY: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = S_DONE;
        end
        S_DONE: begin
          state_d   = S_IDLE;
          retired_d = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
      if (!(stall_req || stall_D)) begin
        e_d       = dec;
        retired_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q       <= CTRL_NOP;
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      retired_q <= 1'b0;
    end else begin
      e_q       <= e_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  assign RegWrite_E   = e_q.regwrite && (!is_md || md_done_E);
  assign MemWrite_E   = e_q.memwrite;
  assign ResultSrc_E  = e_q.resultsrc;
  assign Branch_E     = e_q.branch;
  assign Jump_E       = e_q.jump;
  assign ALUControl_E = e_q.aluctl;
  assign ALUSrcA_E    = e_q.srca;
  assign ALUSrcB_E    = e_q.srcb;
  assign LoadSign_E   = e_q.loadsign;
  assign SizeSrc_E    = e_q.size;
  assign MulDivOp_E   = e_q.mdop;
  assign illegal_E    = e_q.illegal;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Bench for control_unit_pipe: three configurations driven in parallel and compared
// every cycle against an elapsed-time behavioural model, plus literal timing checks.
module tb_control_unit_pipe;

  localparam int NCFG = 3;
  localparam int EN [NCFG] = '{1, 0, 1};
  localparam int ML [NCFG] = '{2, 2, 1};
  localparam int DL [NCFG] = '{33, 33, 5};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_D, funct7_D;
  logic [2:0] funct3_D;
  logic       stall_D, flush_E;
  // {imm[27:25] rw[24] mw[23] rs[22:21] br[20:18] jp[17:16] alu[15:12]
  //  sa[11] sb[10] ls[9] sz[8:7] md[6:4] start[3] done[2] stall[1] ill[0]}
  logic [27:0] outv [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    logic [2:0] imm, br, mdop;
    logic [1:0] rs, jp, sz;
    logic [3:0] alu;
    logic rw, mw, sa, sb, ls, st, dn, sr, il;
    control_unit_pipe #(.ENABLE_M(EN[g]), .MUL_LAT(ML[g]), .DIV_LAT(DL[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .op_D(op_D), .funct3_D(funct3_D), .funct7_D(funct7_D),
      .stall_D(stall_D), .flush_E(flush_E), .ImmSrc_D(imm), .RegWrite_E(rw),
      .MemWrite_E(mw), .ResultSrc_E(rs), .Branch_E(br), .Jump_E(jp),
      .ALUControl_E(alu), .ALUSrcA_E(sa), .ALUSrcB_E(sb), .LoadSign_E(ls),
      .SizeSrc_E(sz), .MulDivOp_E(mdop), .md_start_E(st), .md_done_E(dn),
      .stall_req(sr), .illegal_E(il)
    );
    assign outv[g] = {imm, rw, mw, rs, br, jp, alu, sa, sb, ls, sz, mdop, st, dn, sr, il};
  end

  typedef struct packed {
    logic       rw, mw;
    logic [1:0] rs;
    logic [2:0] br;
    logic [1:0] jp;
    logic [3:0] alu;
    logic       sa, sb, ls;
    logic [1:0] sz;
    logic [2:0] md;
    logic       il;
  } cw_t;

  int n_err = 0, n_chk = 0, cyc = 0;
  cw_t e_m [NCFG];
  bit  started_m [NCFG], cmp_m [NCFG];
  int  el_m [NCFG];
  int  start_cyc [NCFG], done_cyc [NCFG], stall_cnt [NCFG], done_cnt [NCFG];
  int  ld_cyc;

  function automatic cw_t m_nop();
    cw_t c = '0;
    c.br = 3'b010;
    return c;
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
    logic [3:0] tbl [8] = '{4'b0000, 4'b1000, 4'b0110, 4'b0101, 4'b0100, 4'b1001, 4'b0011, 4'b0010};
    if (alt && f3 == 3'b000) return 4'b0001;
    if (alt && f3 == 3'b101) return 4'b1010;
    return tbl[f3];
  endfunction

  function automatic logic [1:0] sz_of(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 2'b10;
    if (f3[1:0] == 2'd1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [2:0] m_imm(input logic [6:0] op, input logic [2:0] f3,
                                       input logic [6:0] f7, input int en);
    case (op)
      7'b0010011: return (f3 == 3'b001 || f3 == 3'b101) ? 3'b101 : 3'b000;
      7'b0000011, 7'b1100111: return 3'b000;
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111, 7'b0010111: return 3'b100;
      7'b0110011: return (f7 == 7'b0000001 && en == 0) ? 3'b111 : 3'b000;
      default: return 3'b111;
    endcase
  endfunction

  function automatic cw_t m_dec(input logic [6:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input int en);
    cw_t c = m_nop();
    case (op)
      7'b0110011:
        if (f7 == 7'b0000001) begin
          if (en != 0) begin c.rw = 1; c.rs = 2'b11; c.md = f3; end
          else c.il = 1;
        end else begin c.rw = 1; c.alu = alu_of(f3, f7[5]); end
      7'b0010011: begin c.rw = 1; c.sb = 1; c.alu = alu_of(f3, f3 == 3'b101 && f7[5]); end
      7'b0000011: begin c.rw = 1; c.rs = 2'b01; c.sb = 1; c.ls = !f3[2]; c.sz = sz_of(f3); end
      7'b0100011: begin c.mw = 1; c.sb = 1; c.sz = sz_of(f3); end
      7'b1100011: begin
        c.alu = 4'b0001;
        if (!(f3 == 3'b010 || f3 == 3'b011)) c.br = f3;
      end
      7'b1101111: begin c.rw = 1; c.rs = 2'b10; c.jp = 2'b10; c.sa = 1; c.sb = 1; end
      7'b1100111: begin c.rw = 1; c.rs = 2'b10; c.jp = 2'b11; c.sb = 1; end
      7'b0110111: begin c.rw = 1; c.sb = 1; c.alu = 4'b0111; end
      7'b0010111: begin c.rw = 1; c.sa = 1; c.sb = 1; end
      default: c.il = 1;
    endcase
    return c;
  endfunction

  function automatic int lat_of(input int g, input cw_t c);
    return c.md[2] ? DL[g] : ML[g];
  endfunction

  // Expected outputs: an M-op waits one start cycle, then counts elapsed cycles up to L.
  function automatic logic [27:0] exp_out(input int g);
    cw_t c = e_m[g];
    int L = lat_of(g, c);
    logic md, st, dn, sl, rw;
    md = (c.rs == 2'b11) && !cmp_m[g];
    st = md && !started_m[g] && !flush_E;
    sl = md && (!started_m[g] || el_m[g] < L);
    dn = started_m[g] && el_m[g] == L && !flush_E;
    rw = c.rw && (c.rs != 2'b11 || dn);
    return {m_imm(op_D, funct3_D, funct7_D, EN[g]), rw, c.mw, c.rs, c.br, c.jp, c.alu,
            c.sa, c.sb, c.ls, c.sz, c.md, st, dn, sl, c.il};
  endfunction

  task automatic model_reset(input int g);
    e_m[g] = m_nop(); started_m[g] = 0; cmp_m[g] = 0; el_m[g] = 0;
  endtask

  task automatic model_step(input int g);
    cw_t c = e_m[g];
    int L = lat_of(g, c);
    logic md, sl;
    if (flush_E) begin
      model_reset(g);
    end else begin
      md = (c.rs == 2'b11) && !cmp_m[g];
      sl = md && (!started_m[g] || el_m[g] < L);
      if (md && !started_m[g]) begin started_m[g] = 1; el_m[g] = 1; end
      else if (started_m[g]) begin
        if (el_m[g] == L) begin started_m[g] = 0; cmp_m[g] = 1; end
        else el_m[g]++;
      end
      if (!(sl || stall_D)) begin
        e_m[g] = m_dec(op_D, funct3_D, funct7_D, EN[g]);
        started_m[g] = 0; cmp_m[g] = 0; el_m[g] = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic checki(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic clr_track();
    for (int g = 0; g < NCFG; g++) begin
      start_cyc[g] = -1; done_cyc[g] = -1; stall_cnt[g] = 0; done_cnt[g] = 0;
    end
    ld_cyc = -1;
  endtask

  task automatic cycle(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic sd, input logic fl);
    op_D = op; funct3_D = f3; funct7_D = f7; stall_D = sd; flush_E = fl;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("cfg%0d_cyc%0d", g, cyc), outv[g], exp_out(g));
      if (outv[g][3]) start_cyc[g] = cyc;
      if (outv[g][2]) begin done_cyc[g] = cyc; done_cnt[g]++; end
      if (outv[g][1]) stall_cnt[g]++;
    end
    if (ld_cyc < 0 && done_cyc[0] >= 0 && outv[0][22:21] != 2'b11) ld_cyc = cyc;
    @(posedge clk);
    for (int g = 0; g < NCFG; g++) model_step(g);
    cyc++;
    #1;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #2;
    for (int g = 0; g < NCFG; g++) begin
      model_reset(g);
      check($sformatf("rst_cfg%0d_cyc%0d", g, cyc), outv[g], exp_out(g));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [6:0] R = 7'b0110011, MD = 7'b0000001, Z7 = 7'b0000000;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [12] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111,
                              7'b0001111, 7'b1110011};
    logic [6:0] rop, rf7;
    int c_ld;
    rst_n = 1'b0; op_D = R; funct3_D = 3'b000; funct7_D = Z7; stall_D = 0; flush_E = 0;
    for (int g = 0; g < NCFG; g++) model_reset(g);
    clr_track();
    @(posedge clk); #1;
    check("reset_word", outv[0], {3'b000, 7'b0000010, 18'b0});
    rst_n = 1'b1;

    cycle(R, 3'b000, Z7, 0, 0);
    checki("add_regwrite", int'(outv[0][24]), 1);
    checki("add_alu", int'(outv[0][15:12]), 0);
    checki("add_rs", int'(outv[0][22:21]), 0);
    checki("add_stall", int'(outv[0][1]), 0);

    clr_track();
    cycle(R, 3'b000, MD, 0, 0);
    checki("nom_illegal", int'(outv[1][0]), 1);
    checki("nom_regwrite", int'(outv[1][24]), 0);
    checki("nom_memwrite", int'(outv[1][23]), 0);
    for (int i = 0; i < 5; i++) cycle(R, 3'b000, Z7, 0, 0);
    checki("mul_lat", done_cyc[0] - start_cyc[0], 2);
    checki("mul_stall", stall_cnt[0], 2);
    checki("mul1_lat", done_cyc[2] - start_cyc[2], 1);
    checki("mul1_stall", stall_cnt[2], 1);

    clr_track();
    cycle(R, 3'b101, MD, 0, 0);
    for (int i = 0; i < 40; i++) cycle(R, 3'b000, Z7, 0, 0);
    checki("divu_lat", done_cyc[0] - start_cyc[0], 33);
    checki("divu_stall", stall_cnt[0], 33);
    checki("divu_next_load", ld_cyc - done_cyc[0], 1);
    checki("div5_lat", done_cyc[2] - start_cyc[2], 5);

    clr_track();
    cycle(R, 3'b100, MD, 0, 0);
    for (int i = 0; i < 5; i++) cycle(R, 3'b000, Z7, 0, 0);
    cycle(R, 3'b000, Z7, 0, 1);
    checki("flush_stall", int'(outv[0][1]), 0);
    checki("flush_rs", int'(outv[0][22:21]), 0);
    checki("flush_no_done", done_cnt[0], 0);
    checki("flush_no_done5", done_cnt[2], 0);
    clr_track();
    cycle(R, 3'b000, MD, 0, 0);
    c_ld = cyc;
    for (int i = 0; i < 4; i++) cycle(R, 3'b000, Z7, 0, 0);
    checki("postflush_start", start_cyc[0], c_ld);
    checki("postflush_lat", done_cyc[0] - start_cyc[0], 2);

    cycle(7'b1111111, 3'b000, Z7, 0, 0);
    checki("ill_imm", int'(outv[0][27:25]), 7);
    checki("ill_flag", int'(outv[0][0]), 1);
    checki("ill_rw_mw", int'(outv[0][24:23]), 0);

    cycle(7'b1100011, 3'b000, Z7, 0, 0);
    cycle(7'b1100011, 3'b110, Z7, 1, 0);
    checki("bltu_hold", int'(outv[0][20:18]), 0);
    cycle(7'b1100011, 3'b110, Z7, 0, 0);
    checki("bltu_load", int'(outv[0][20:18]), 6);

    cycle(R, 3'b100, MD, 0, 0);
    for (int i = 0; i < 5; i++) cycle(R, 3'b000, Z7, 0, 0);
    checki("middiv_stall", int'(outv[0][1]), 1);
    async_reset();

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 299) == 0) async_reset();
      else begin
        rop = ($urandom_range(0, 12) == 12) ? 7'($urandom) : ops[$urandom_range(0, 11)];
        case ($urandom_range(0, 3))
          0: rf7 = Z7;
          1: rf7 = 7'b0100000;
          2: rf7 = MD;
          default: rf7 = 7'($urandom);
        endcase
        cycle(rop, 3'($urandom_range(0, 7)), rf7,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
